// File: rtl/dtw_pe_gen.sv
// rtl/dtw_pe_gen.sv - DTW processing element: source select, local distance, min-plus accumulate
module dtw_pe_gen #(
  parameter int DIM = 3,
  parameter int VW  = 10,
  parameter int DW  = 16,
  parameter int IW  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic                mode,
  input  logic [DW-1:0]       D0,
  input  logic [DW-1:0]       D1,
  input  logic [DW-1:0]       D2,
  input  logic [DIM*VW-1:0]   T_prev,
  input  logic [DIM*VW-1:0]   T_global,
  input  logic [DIM*VW-1:0]   R_prev,
  input  logic [DIM*VW-1:0]   R_global,
  input  logic [IW-1:0]       i_tindex_prev,
  input  logic [IW-1:0]       i_tindex_global,
  input  logic [IW-1:0]       i_rindex_prev,
  input  logic [IW-1:0]       i_rindex_global,
  input  logic [1:0]          i_tsrc,
  input  logic [1:0]          i_rsrc,
  output logic [DIM*VW-1:0]   T,
  output logic [DIM*VW-1:0]   R,
  output logic [IW-1:0]       o_tindex,
  output logic [IW-1:0]       o_rindex,
  output logic                out_valid,
  output logic [DW-1:0]       D,
  output logic [1:0]          o_path,
  output logic                sat
);

  // Full-width channel sum: squared L2 of VW+1-bit diffs, summed over DIM channels.
  localparam int SW = 2*VW + 2 + $clog2(DIM);
  localparam int CW = (SW > DW) ? SW : DW;
  localparam logic [DW-1:0] DMAX = '1;

  logic [DIM*VW-1:0] t_sel, r_sel;
  logic [IW-1:0]     t_tag_sel, r_tag_sel;
  logic [SW-1:0]     term [DIM];
  logic [SW-1:0]     sum;
  logic [CW-1:0]     sum_w;
  logic [DW-1:0]     l_comb, m_comb;
  logic [1:0]        path_comb;

  logic              v1_q;
  logic [DW-1:0]     l_q, m_q;
  logic [1:0]        path_q;
  logic [DW:0]       tot;

  // Template source select; src 0 and 3 re-use the registered vector and tag.
  always_comb begin
    t_sel     = T;
    t_tag_sel = o_tindex;
    case (i_tsrc)
      2'd1: begin
        t_sel     = T_prev;
        t_tag_sel = i_tindex_prev;
      end
      2'd2: begin
        t_sel     = T_global;
        t_tag_sel = i_tindex_global;
      end
      default: begin
        t_sel     = T;
        t_tag_sel = o_tindex;
      end
    endcase
  end

  // Reference source select, same encoding as the template side.
  always_comb begin
    r_sel     = R;
    r_tag_sel = o_rindex;
    case (i_rsrc)
      2'd1: begin
        r_sel     = R_prev;
        r_tag_sel = i_rindex_prev;
      end
      2'd2: begin
        r_sel     = R_global;
        r_tag_sel = i_rindex_global;
      end
      default: begin
        r_sel     = R;
        r_tag_sel = o_rindex;
      end
    endcase
  end

  // Per-channel signed difference and its L1 / squared-L2 contribution.
  for (genvar c = 0; c < DIM; c++) begin : g_ch
    logic signed [VW-1:0]   t_c, r_c;
    logic signed [VW:0]     diff;
    logic signed [2*VW+1:0] dx;
    logic signed [2*VW+1:0] sq;
    logic [VW:0]            absd;

    assign t_c     = t_sel[(DIM-c)*VW-1 -: VW];
    assign r_c     = r_sel[(DIM-c)*VW-1 -: VW];
    assign diff    = {r_c[VW-1], r_c} - {t_c[VW-1], t_c};
    assign absd    = diff[VW] ? $unsigned(-diff) : $unsigned(diff);
    assign dx      = (2*VW+2)'(diff);
    assign sq      = dx * dx;
    assign term[c] = mode ? SW'($unsigned(sq)) : SW'(absd);
  end

  // Sum channel terms at full width and clamp to the cost range.
  always_comb begin
    sum = '0;
    for (int c = 0; c < DIM; c++) begin
      sum = sum + term[c];
    end
    sum_w  = CW'(sum);
    l_comb = (sum_w > CW'(DMAX)) ? DMAX : sum_w[DW-1:0];
  end

  // Minimum of neighbour costs; ties favour diagonal, then (i-1,j).
  always_comb begin
    m_comb    = D2;
    path_comb = 2'b01;
    if (D0 <= D1 && D0 <= D2) begin
      m_comb    = D0;
      path_comb = 2'b11;
    end else if (D1 <= D2) begin
      m_comb    = D1;
      path_comb = 2'b10;
    end
  end

  // Registered T/R vectors and tags forwarded to the next PE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      T        <= '0;
      R        <= '0;
      o_tindex <= '1;
      o_rindex <= '1;
    end else if (clr) begin
      T        <= '0;
      R        <= '0;
      o_tindex <= '1;
      o_rindex <= '1;
    end else if (in_valid) begin
      T        <= t_sel;
      R        <= r_sel;
      o_tindex <= t_tag_sel;
      o_rindex <= r_tag_sel;
    end
  end

  // Stage 1: capture local distance, chosen neighbour and path code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      l_q    <= '0;
      m_q    <= '0;
      path_q <= 2'b00;
    end else if (clr) begin
      v1_q   <= 1'b0;
      l_q    <= '0;
      m_q    <= '0;
      path_q <= 2'b00;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        l_q    <= l_comb;
        m_q    <= m_comb;
        path_q <= path_comb;
      end
    end
  end

  assign tot = {1'b0, l_q} + {1'b0, m_q};

  // Stage 2: saturating accumulate; results hold across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      D         <= '0;
      o_path    <= 2'b00;
      sat       <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      D         <= '0;
      o_path    <= 2'b00;
      sat       <= 1'b0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        D      <= tot[DW] ? DMAX : tot[DW-1:0];
        o_path <= path_q;
        sat    <= tot[DW] | (&m_q);
      end
    end
  end

endmodule

// File: tb/tb_dtw_pe_gen.sv
// tb/tb_dtw_pe_gen.sv - randomized and directed self-checking bench for dtw_pe_gen
module tb_dtw_pe_gen;

  localparam int DIM = 3;
  localparam int VW  = 10;
  localparam int DW  = 16;
  localparam int IW  = 5;
  localparam int CMAX = 65535;

  logic clk = 1'b0;
  logic rst, clr, in_valid, mode;
  logic [DW-1:0] D0, D1, D2;
  logic [DIM*VW-1:0] T_prev, T_global, R_prev, R_global;
  logic [IW-1:0] i_tindex_prev, i_tindex_global, i_rindex_prev, i_rindex_global;
  logic [1:0] i_tsrc, i_rsrc;
  logic [DIM*VW-1:0] T, R;
  logic [IW-1:0] o_tindex, o_rindex;
  logic out_valid, sat;
  logic [DW-1:0] D;
  logic [1:0] o_path;

  int checks = 0;
  int errors = 0;

  dtw_pe_gen #(.DIM(DIM), .VW(VW), .DW(DW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .mode(mode),
    .D0(D0), .D1(D1), .D2(D2),
    .T_prev(T_prev), .T_global(T_global), .R_prev(R_prev), .R_global(R_global),
    .i_tindex_prev(i_tindex_prev), .i_tindex_global(i_tindex_global),
    .i_rindex_prev(i_rindex_prev), .i_rindex_global(i_rindex_global),
    .i_tsrc(i_tsrc), .i_rsrc(i_rsrc),
    .T(T), .R(R), .o_tindex(o_tindex), .o_rindex(o_rindex),
    .out_valid(out_valid), .D(D), .o_path(o_path), .sat(sat)
  );

  always #5 clk = ~clk;

  function automatic logic [DIM*VW-1:0] pack3(input int a, input int b, input int c);
    pack3 = {10'(a), 10'(b), 10'(c)};
  endfunction

  function automatic int chan(input logic [DIM*VW-1:0] v, input int c);
    logic signed [VW-1:0] x;
    x = v[(DIM-1-c)*VW +: VW];
    return int'(x);
  endfunction

  // Reference: DTW recurrence from plain integer arithmetic.
  task automatic model(input logic [DIM*VW-1:0] tv, input logic [DIM*VW-1:0] rv,
                       input logic md, input int a, input int b, input int c,
                       output int ed, output logic [1:0] ep, output logic es);
    int s, dff, l, m, tot;
    s = 0;
    for (int k = 0; k < DIM; k++) begin
      dff = chan(rv, k) - chan(tv, k);
      s += md ? dff * dff : (dff < 0 ? -dff : dff);
    end
    l = (s > CMAX) ? CMAX : s;
    if (a <= b && a <= c) begin m = a; ep = 2'b11; end
    else if (b <= c) begin m = b; ep = 2'b10; end
    else begin m = c; ep = 2'b01; end
    tot = l + m;
    ed = (tot > CMAX) ? CMAX : tot;
    es = (tot > CMAX) || (m == CMAX);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; clr = 1'b0; mode = 1'b0;
    D0 = '0; D1 = '0; D2 = '0;
    T_prev = '0; T_global = '0; R_prev = '0; R_global = '0;
    i_tindex_prev = 5'd3; i_tindex_global = 5'd6;
    i_rindex_prev = 5'd4; i_rindex_global = 5'd9;
    i_tsrc = 2'd0; i_rsrc = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic set_beat(input logic md, input logic [1:0] src,
                          input logic [DIM*VW-1:0] tv, input logic [DIM*VW-1:0] rv,
                          input int a, input int b, input int c);
    in_valid = 1'b1; mode = md; i_tsrc = src; i_rsrc = src;
    T_prev   = (src == 2'd1) ? tv : 30'($urandom);
    T_global = (src == 2'd2) ? tv : 30'($urandom);
    R_prev   = (src == 2'd1) ? rv : 30'($urandom);
    R_global = (src == 2'd2) ? rv : 30'($urandom);
    D0 = 16'(a); D1 = 16'(b); D2 = 16'(c);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #3;
    checks++;
    if (T !== '0 || R !== '0 || o_tindex !== 5'h1f || o_rindex !== 5'h1f ||
        D !== '0 || o_path !== 2'b00 || sat !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state T=%h R=%h ti=%h ri=%h D=%0d p=%b s=%b v=%b want zeros/tags 1f",
               T, R, o_tindex, o_rindex, D, o_path, sat, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_l1_l2_basic();
    logic [DIM*VW-1:0] tv, rv;
    tv = pack3(2, 4, 100);
    rv = pack3(5, -3, 100);
    for (int md = 0; md < 2; md++) begin
      do_reset();
      set_beat(1'(md), 2'd2, tv, rv, 20, 15, 15);
      @(posedge clk); #1;
      checks++;
      if (T !== tv || R !== rv || o_tindex !== 5'd6 || o_rindex !== 5'd9 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_regs md=%0d T=%h R=%h ti=%0d ri=%0d v=%b want T=%h R=%h ti=6 ri=9 v=0",
                 md, T, R, o_tindex, o_rindex, out_valid, tv, rv);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || D !== ((md == 0) ? 16'd25 : 16'd73) || o_path !== 2'b10 || sat !== 1'b0) begin
        errors++;
        $display("FAIL basic_out md=%0d v=%b D=%0d p=%b s=%b want v=1 D=%0d p=10 s=0",
                 md, out_valid, D, o_path, sat, (md == 0) ? 25 : 73);
      end
    end
  endtask

  task automatic test_back_to_back_ties_sat();
    logic [DIM*VW-1:0] tv, rv;
    int exp_d [3];
    logic [1:0] exp_p [3];
    logic exp_s [3];
    tv = pack3(2, 4, 100);
    rv = pack3(5, -3, 100);
    exp_d = '{7, 65535, 65535};
    exp_p = '{2'b11, 2'b11, 2'b11};
    exp_s = '{1'b0, 1'b1, 1'b1};
    do_reset();
    set_beat(1'b0, 2'd2, tv, tv, 7, 7, 7);
    @(posedge clk); #1;
    set_beat(1'b0, 2'd2, tv, rv, 65530, 65535, 65535);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || D !== 16'(exp_d[k]) || o_path !== exp_p[k] || sat !== exp_s[k]) begin
        errors++;
        $display("FAIL tie_sat_%0d v=%b D=%0d p=%b s=%b want v=1 D=%0d p=%b s=%b",
                 k, out_valid, D, o_path, sat, exp_d[k], exp_p[k], exp_s[k]);
      end
      if (k == 0) set_beat(1'b0, 2'd2, tv, rv, 65535, 65535, 65535);
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b0 || D !== 16'hffff || sat !== 1'b1) begin
      errors++;
      $display("FAIL tie_sat_bubble v=%b D=%0d s=%b want v=0 D=65535 s=1", out_valid, D, sat);
    end
  endtask

  task automatic test_hold_forward();
    logic [DIM*VW-1:0] tv, rv;
    tv = pack3(1, 2, 3);
    rv = pack3(10, -10, 0);
    do_reset();
    set_beat(1'b0, 2'd1, tv, rv, 0, 0, 0);
    @(posedge clk); #1;
    set_beat(1'b0, 2'd0, pack3(0, 0, 0), pack3(0, 0, 0), 100, 50, 40);
    i_tindex_prev = 5'd17; i_tindex_global = 5'd18;
    i_rindex_prev = 5'd19; i_rindex_global = 5'd20;
    @(posedge clk); #1;
    checks++;
    if (T !== tv || R !== rv || o_tindex !== 5'd3 || o_rindex !== 5'd4 ||
        out_valid !== 1'b1 || D !== 16'd24 || o_path !== 2'b11) begin
      errors++;
      $display("FAIL hold_A T=%h R=%h ti=%0d ri=%0d v=%b D=%0d p=%b want T=%h R=%h ti=3 ri=4 v=1 D=24 p=11",
               T, R, o_tindex, o_rindex, out_valid, D, o_path, tv, rv);
    end
    in_valid = 1'b0;
    i_tsrc = 2'd2; i_rsrc = 2'd1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || D !== 16'd64 || o_path !== 2'b01 || sat !== 1'b0) begin
      errors++;
      $display("FAIL hold_B v=%b D=%0d p=%b s=%b want v=1 D=64 p=01 s=0", out_valid, D, o_path, sat);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || D !== 16'd64 || o_path !== 2'b01 || T !== tv || R !== rv || o_tindex !== 5'd3) begin
      errors++;
      $display("FAIL hold_bubble v=%b D=%0d p=%b T=%h R=%h ti=%0d want v=0 D=64 p=01 T/R held ti=3",
               out_valid, D, o_path, T, R, o_tindex);
    end
  endtask

  task automatic test_extremes();
    do_reset();
    set_beat(1'b0, 2'd2, pack3(511, 511, 511), pack3(-512, -512, -512), 1000, 1000, 1000);
    @(posedge clk); #1;
    set_beat(1'b1, 2'd2, pack3(511, 511, 511), pack3(-512, -512, -512), 0, 0, 0);
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || D !== 16'd4069 || sat !== 1'b0 || o_path !== 2'b11) begin
      errors++;
      $display("FAIL extreme_l1 v=%b D=%0d s=%b p=%b want v=1 D=4069 s=0 p=11", out_valid, D, sat, o_path);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || D !== 16'hffff || sat !== 1'b0) begin
      errors++;
      $display("FAIL extreme_l2 v=%b D=%0d s=%b want v=1 D=65535 s=0", out_valid, D, sat);
    end
  endtask

  task automatic test_rst_midpipe();
    do_reset();
    set_beat(1'b0, 2'd2, pack3(1, 1, 1), pack3(3, 3, 3), 5, 6, 7);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if (T !== '0 || R !== '0 || o_tindex !== 5'h1f || o_rindex !== 5'h1f ||
        D !== '0 || o_path !== 2'b00 || sat !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async T=%h ti=%h D=%0d p=%b s=%b v=%b want reset values",
               T, o_tindex, D, o_path, sat, out_valid);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || D !== '0) begin
        errors++;
        $display("FAIL rst_after_%0d v=%b D=%0d want v=0 D=0", k, out_valid, D);
      end
    end
  endtask

  task automatic test_clr();
    do_reset();
    set_beat(1'b0, 2'd2, pack3(1, 1, 1), pack3(3, 3, 3), 5, 6, 7);
    @(posedge clk); #1;
    set_beat(1'b0, 2'd2, pack3(9, 9, 9), pack3(0, 0, 0), 1, 2, 3);
    clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (T !== '0 || R !== '0 || o_tindex !== 5'h1f || out_valid !== 1'b0 || D !== '0 || o_path !== 2'b00) begin
      errors++;
      $display("FAIL clr_state T=%h ti=%h v=%b D=%0d p=%b want cleared", T, o_tindex, out_valid, D, o_path);
    end
    clr = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || T !== '0) begin
      errors++;
      $display("FAIL clr_drop v=%b T=%h want v=0 T=0", out_valid, T);
    end
  endtask

  task automatic test_random();
    logic [DIM*VW-1:0] mt, mr, tsel, rsel;
    logic [IW-1:0] mti, mri;
    logic pv, nv, ev, np_s, pp_s, es;
    int pd, nd, ed;
    logic [1:0] pp, np, ep;
    do_reset();
    mt = '0; mr = '0; mti = '1; mri = '1;
    pv = 1'b0; pd = 0; pp = 2'b00; pp_s = 1'b0;
    ed = 0; ep = 2'b00; es = 1'b0;
    nd = 0; np = 2'b00; np_s = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 40) == 0);
      mode = 1'($urandom_range(0, 1));
      i_tsrc = 2'($urandom_range(0, 3));
      i_rsrc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        T_prev   = pack3($urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20);
        T_global = pack3($urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20);
        R_prev   = pack3($urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20);
        R_global = pack3($urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20, $urandom_range(0, 40) - 20);
      end else begin
        T_prev = 30'($urandom); T_global = 30'($urandom);
        R_prev = 30'($urandom); R_global = 30'($urandom);
      end
      i_tindex_prev = 5'($urandom); i_tindex_global = 5'($urandom);
      i_rindex_prev = 5'($urandom); i_rindex_global = 5'($urandom);
      D0 = ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom_range(0, 3) == 0 ? 65535 - $urandom_range(0, 50) : $urandom_range(0, 2000));
      D1 = ($urandom_range(0, 3) == 0) ? 16'hffff : 16'($urandom_range(0, 3) == 0 ? 65535 - $urandom_range(0, 50) : $urandom_range(0, 2000));
      D2 = ($urandom_range(0, 3) == 0) ? D1 : 16'($urandom_range(0, 2000));
      nv = 1'b0;
      if (!clr && in_valid) begin
        tsel = (i_tsrc == 2'd1) ? T_prev : (i_tsrc == 2'd2) ? T_global : mt;
        rsel = (i_rsrc == 2'd1) ? R_prev : (i_rsrc == 2'd2) ? R_global : mr;
        model(tsel, rsel, mode, int'(D0), int'(D1), int'(D2), nd, np, np_s);
        nv = 1'b1;
        if (i_tsrc == 2'd1) mti = i_tindex_prev; else if (i_tsrc == 2'd2) mti = i_tindex_global;
        if (i_rsrc == 2'd1) mri = i_rindex_prev; else if (i_rsrc == 2'd2) mri = i_rindex_global;
        mt = tsel; mr = rsel;
      end
      @(posedge clk); #1;
      if (clr) begin
        mt = '0; mr = '0; mti = '1; mri = '1;
        ev = 1'b0; ed = 0; ep = 2'b00; es = 1'b0; pv = 1'b0;
      end else begin
        ev = pv;
        if (pv) begin ed = pd; ep = pp; es = pp_s; end
        pv = nv; pd = nd; pp = np; pp_s = np_s;
      end
      checks++;
      if (T !== mt || R !== mr || o_tindex !== mti || o_rindex !== mri) begin
        errors++;
        $display("FAIL rand_regs cyc=%0d T=%h R=%h ti=%0d ri=%0d want T=%h R=%h ti=%0d ri=%0d",
                 cyc, T, R, o_tindex, o_rindex, mt, mr, mti, mri);
      end
      checks++;
      if (out_valid !== ev || D !== 16'(ed) || o_path !== ep || sat !== es) begin
        errors++;
        $display("FAIL rand_out cyc=%0d v=%b D=%0d p=%b s=%b want v=%b D=%0d p=%b s=%b",
                 cyc, out_valid, D, o_path, sat, ev, ed, ep, es);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_l1_l2_basic();
    test_back_to_back_ties_sat();
    test_hold_forward();
    test_extremes();
    test_rst_midpipe();
    test_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
